icetap_scan_stream: RTL and testbench
=====================================

ICETAP_SCAN_STREAM -- requirements
Module: icetap_scan_stream

Interface
- REQ-001 Parameter NR_SIGNALS, default 16: width of one recorded sample word.
- REQ-002 Parameter RECORD_DEPTH, default 256: maximum words read per data scan; RAM_ADDR_BITS = clog2(RECORD_DEPTH).
- REQ-003 Parameter STATUS_BITS, default 64: status vector width, zero-padded up to a multiple of CHUNK_BITS.
- REQ-004 Parameter CHUNK_BITS, default 8: status capture chunk size.
- REQ-005 Parameter STATUS_SNAPSHOT, default 0: 1 = capture the whole status vector at update; 0 = capture chunk by chunk.
- REQ-006 Port scan_clk, in, 1: sole clock, rising edge.
- REQ-007 Port scan_reset_, in, 1: reset, asynchronous assert, active-low.
- REQ-008 Port status_shift_update, in, 1: start a status scan.
- REQ-009 Port status_shift_ena, in, 1: advance the status scan one bit.
- REQ-010 Port status_vec, in, STATUS_BITS: status to scan out.
- REQ-011 Port status_shift_data, out, 1: serial status, LSB first.
- REQ-012 Port data_shift_update, in, 1: start a data scan.
- REQ-013 Port data_shift_ena, in, 1: advance the data scan one bit.
- REQ-014 Port data_shift_data, out, 1: serial sample data, word 0 LSB first.
- REQ-015 Port read_req_first, out, 1: one-cycle pulse requesting the first word.
- REQ-016 Port read_req_next, out, 1: one-cycle pulse requesting the following word.
- REQ-017 Port read_valid, in, 1: read_data is valid for the oldest outstanding request.
- REQ-018 Port read_data, in, NR_SIGNALS: returned sample word.
- REQ-019 Port data_underrun, out, 1: sticky; a shift occurred with no word loaded.
- REQ-020 Port data_done, out, 1: all RECORD_DEPTH words have been shifted out.
- REQ-021 Port word_cnt, out, RAM_ADDR_BITS+1: words fully shifted since the last update.

Function
- REQ-022 The status scan shall use a CHUNK_BITS shift register and a bit/chunk index.
- REQ-023 On status_shift_update, chunk 0 shall be loaded and the index cleared.
- REQ-024 On each status_shift_ena shift other than a chunk's last bit, the status register shall shift right with zero fill.
- REQ-025 On a chunk's last bit, the status register shall load the next chunk.
- REQ-026 After the final chunk, the status scan shall output 0 until the next status update.
- REQ-027 With STATUS_SNAPSHOT=0, each chunk shall be taken from status_vec at its load cycle.
- REQ-028 With STATUS_SNAPSHOT=1, every chunk shall come from the copy latched at the update cycle.
- REQ-029 status_shift_update shall take priority over a coincident status_shift_ena.
- REQ-030 The data FSM shall have states IDLE, FILL and RUN.
- REQ-031 data_shift_update shall take priority in any state: it clears the buffers, the data_underrun/data_done flags, word_cnt and the request count, enters FILL, and pulses read_req_first on the next cycle.
- REQ-032 The data path shall hold at most one outstanding request.
- REQ-033 read_valid shall be ignored when no request is outstanding, including in the update cycle.
- REQ-034 Returned words shall go to a one-word hold register.
- REQ-035 When the shift register is empty and the hold register is valid, the hold word shall move to the shift register, and read_req_next shall pulse the next cycle if fewer than RECORD_DEPTH words have been requested.
- REQ-036 FILL shall go to RUN on the first such move.
- REQ-037 In RUN, each data_shift_ena shall shift the register right.
- REQ-038 On the word's last bit, word_cnt shall increment, and the hold word, if valid, shall load in the same cycle with no bubble.
- REQ-039 A data_shift_ena with no word loaded shall output 0 and set data_underrun, unless data_done is set.
- REQ-040 data_done shall set when word_cnt reaches RECORD_DEPTH; afterwards shifts shall output 0 and no further requests shall be issued.
- REQ-041 word_cnt shall saturate at RECORD_DEPTH.
- REQ-042 All serial outputs shall be driven directly from flip-flops.

Reset
- REQ-043 Asserting scan_reset_ shall immediately clear all registers, return the FSM to IDLE, and drive every output to 0, including mid-scan; no pulse shall be emitted on release.

Verification
- REQ-044 status_vec=64'h0123456789ABCDEF, update, then 72 shifts -> the stream equals the vector LSB first, followed by 8 zeros.
- REQ-045 STATUS_SNAPSHOT=1, status_vec changed after update -> the original value is scanned; with STATUS_SNAPSHOT=0, the chunks loaded after the change carry the new value.
- REQ-046 Data update, read_valid 2 cycles after each request, words 16'hA5A5 and 16'h3C3C, continuous ena -> read_req_first, then read_req_next on the first load; 32 contiguous bits, no underrun.
- REQ-047 Memory returns data 20 cycles late with continuous ena -> zeros are output and data_underrun=1 until the next update.
- REQ-048 RECORD_DEPTH=4 -> exactly 4 requests, word_cnt=4, data_done=1, subsequent shifts output 0 with data_underrun=0.
- REQ-049 Reset asserted mid-word, and an update coincident with ena -> all outputs 0 immediately; the update wins and read_req_first follows one cycle later.

Source files
------------

// File: rtl/icetap_scan_stream.sv
// icetap_scan_stream
//   Serial scan-out of a status vector and of recorded sample words.
//
//   Status path: a CHUNK_BITS shift register walks the (zero-padded) status
//   vector chunk by chunk, LSB first. Chunks come either from the live
//   status_vec at their load cycle, or from a copy latched at the update
//   (STATUS_SNAPSHOT=1).
//
//   Data path: an IDLE/FILL/RUN FSM requests sample words one at a time from
//   an external memory, parks each returned word in a one-word hold register
//   and streams it out of a NR_SIGNALS shift register, LSB first.
//
// Ports
//   scan_clk, scan_reset_                 clock (rising edge), async active-low reset
//   status_shift_update/_ena, status_vec  status scan control and source
//   status_shift_data                     serial status out
//   data_shift_update/_ena                data scan control
//   data_shift_data                       serial sample data out
//   read_req_first, read_req_next         one-cycle memory request pulses
//   read_valid, read_data                 memory return
//   data_underrun                         sticky: shifted with no word loaded
//   data_done                             RECORD_DEPTH words shifted out
//   word_cnt                              words fully shifted since update
module icetap_scan_stream #(
  parameter int NR_SIGNALS      = 16,
  parameter int RECORD_DEPTH    = 256,
  parameter int STATUS_BITS     = 64,
  parameter int CHUNK_BITS      = 8,
  parameter int STATUS_SNAPSHOT = 0,
  localparam int RAM_ADDR_BITS  = $clog2(RECORD_DEPTH)
) (
  input  logic                     scan_clk,
  input  logic                     scan_reset_,
  input  logic                     status_shift_update,
  input  logic                     status_shift_ena,
  input  logic [STATUS_BITS-1:0]   status_vec,
  output logic                     status_shift_data,
  input  logic                     data_shift_update,
  input  logic                     data_shift_ena,
  output logic                     data_shift_data,
  output logic                     read_req_first,
  output logic                     read_req_next,
  input  logic                     read_valid,
  input  logic [NR_SIGNALS-1:0]    read_data,
  output logic                     data_underrun,
  output logic                     data_done,
  output logic [RAM_ADDR_BITS:0]   word_cnt
);

  // ---------------------------------------------------------------------
  // Status scan
  // ---------------------------------------------------------------------
  localparam int NCHUNKS = (STATUS_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int PADW    = NCHUNKS * CHUNK_BITS;
  localparam int CHW     = (CHUNK_BITS > 1) ? $clog2(CHUNK_BITS) : 1;
  localparam int CIW     = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

  logic [CHUNK_BITS-1:0] st_sr_q;
  logic [CHW-1:0]        st_bit_q;
  logic [CIW-1:0]        st_chunk_q;
  logic                  st_active_q;
  logic [PADW-1:0]       st_snap_q;

  logic [PADW-1:0]       live_pad;
  logic [PADW-1:0]       src_pad;
  logic [PADW-1:0]       src_shift;
  logic [CHUNK_BITS-1:0] next_chunk;

  always_comb begin
    live_pad   = PADW'(status_vec);
    src_pad    = (STATUS_SNAPSHOT != 0) ? st_snap_q : live_pad;
    // Shift rather than index so the unused "chunk after the last" case
    // never produces an out-of-range part select.
    src_shift  = src_pad >> (CHUNK_BITS * (int'(st_chunk_q) + 1));
    next_chunk = src_shift[CHUNK_BITS-1:0];
  end

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      st_sr_q     <= '0;
      st_bit_q    <= '0;
      st_chunk_q  <= '0;
      st_active_q <= 1'b0;
      st_snap_q   <= '0;
    end else if (status_shift_update) begin
      // Chunk 0 always comes from the live vector; in snapshot mode that is
      // the very value being latched this cycle.
      st_sr_q     <= live_pad[CHUNK_BITS-1:0];
      st_bit_q    <= '0;
      st_chunk_q  <= '0;
      st_active_q <= 1'b1;
      if (STATUS_SNAPSHOT != 0) st_snap_q <= live_pad;
    end else if (status_shift_ena && st_active_q) begin
      if (st_bit_q == CHW'(CHUNK_BITS - 1)) begin
        st_bit_q <= '0;
        if (st_chunk_q == CIW'(NCHUNKS - 1)) begin
          st_active_q <= 1'b0;
          st_sr_q     <= '0;
        end else begin
          st_chunk_q <= st_chunk_q + 1'b1;
          st_sr_q    <= next_chunk;
        end
      end else begin
        st_sr_q  <= st_sr_q >> 1;
        st_bit_q <= st_bit_q + 1'b1;
      end
    end
  end

  assign status_shift_data = st_sr_q[0];

  // ---------------------------------------------------------------------
  // Data scan
  // ---------------------------------------------------------------------
  localparam int CW  = RAM_ADDR_BITS + 1;
  localparam int BCW = (NR_SIGNALS > 1) ? $clog2(NR_SIGNALS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RECORD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} dstate_e;

  dstate_e               state_q;
  logic [NR_SIGNALS-1:0] shreg_q;
  logic                  sh_valid_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [NR_SIGNALS-1:0] hold_q;
  logic                  hold_valid_q;
  logic                  outstanding_q;
  logic [CW-1:0]         req_cnt_q;
  logic [CW-1:0]         word_cnt_q;
  logic                  underrun_q;
  logic                  done_q;
  logic                  req_first_q;
  logic                  req_next_q;

  logic shift_go;
  logic last_bit;
  logic do_load;
  logic underrun_evt;

  always_comb begin
    last_bit     = (bit_cnt_q == BCW'(NR_SIGNALS - 1));
    shift_go     = (state_q == S_RUN) && data_shift_ena && sh_valid_q;
    // Load when the shift register is empty, or back-to-back on the last bit.
    do_load      = (state_q != S_IDLE) && hold_valid_q && !done_q &&
                   (!sh_valid_q || (shift_go && last_bit));
    underrun_evt = (state_q == S_RUN) && data_shift_ena && !sh_valid_q && !done_q;
  end

  always_ff @(posedge scan_clk or negedge scan_reset_) begin
    if (!scan_reset_) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      sh_valid_q    <= 1'b0;
      bit_cnt_q     <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      outstanding_q <= 1'b0;
      req_cnt_q     <= '0;
      word_cnt_q    <= '0;
      underrun_q    <= 1'b0;
      done_q        <= 1'b0;
      req_first_q   <= 1'b0;
      req_next_q    <= 1'b0;
    end else if (data_shift_update) begin
      // The first request is counted and marked outstanding here so that it
      // is live during the read_req_first pulse cycle.
      state_q       <= S_FILL;
      shreg_q       <= '0;
      sh_valid_q    <= 1'b0;
      bit_cnt_q     <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      outstanding_q <= 1'b1;
      req_cnt_q     <= CW'(1);
      word_cnt_q    <= '0;
      underrun_q    <= 1'b0;
      done_q        <= 1'b0;
      req_first_q   <= 1'b1;
      req_next_q    <= 1'b0;
    end else begin
      req_first_q <= 1'b0;
      req_next_q  <= 1'b0;

      if (read_valid && outstanding_q) begin
        hold_q        <= read_data;
        hold_valid_q  <= 1'b1;
        outstanding_q <= 1'b0;
      end

      if (underrun_evt) underrun_q <= 1'b1;

      if (shift_go) begin
        if (last_bit) begin
          shreg_q    <= '0;
          sh_valid_q <= 1'b0;
          bit_cnt_q  <= '0;
          if (word_cnt_q != DEPTH_C) word_cnt_q <= word_cnt_q + 1'b1;
          if (word_cnt_q == DEPTH_C - 1'b1) done_q <= 1'b1;
        end else begin
          shreg_q   <= shreg_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      // Placed after the shift so a same-cycle load overrides the clear.
      if (do_load) begin
        shreg_q      <= hold_q;
        sh_valid_q   <= 1'b1;
        bit_cnt_q    <= '0;
        hold_valid_q <= 1'b0;
        state_q      <= S_RUN;
        if (req_cnt_q < DEPTH_C) begin
          req_next_q    <= 1'b1;
          outstanding_q <= 1'b1;
          req_cnt_q     <= req_cnt_q + 1'b1;
        end
      end
    end
  end

  assign data_shift_data = shreg_q[0];
  assign read_req_first  = req_first_q;
  assign read_req_next   = req_next_q;
  assign data_underrun   = underrun_q;
  assign data_done       = done_q;
  assign word_cnt        = word_cnt_q;

endmodule

// File: tb/tb_icetap_scan_stream.sv
module tb_icetap_scan_stream;

  logic scan_clk = 1'b0;
  logic scan_reset_ = 1'b0;
  always #5 scan_clk = ~scan_clk;

  logic [63:0] status_vec;
  logic        st_upd, st_ena;

  // DUT A: defaults (depth 256, live status chunks)
  logic        upd_a, ena_a, rv_a;
  logic [15:0] rd_a;
  logic        ss_a, ds_a, rf_a, rn_a, ur_a, dn_a;
  logic [8:0]  wc_a;
  // DUT B: depth 4, status snapshot
  logic        upd_b, ena_b, rv_b;
  logic [15:0] rd_b;
  logic        ss_b, ds_b, rf_b, rn_b, ur_b, dn_b;
  logic [2:0]  wc_b;

  icetap_scan_stream #(.NR_SIGNALS(16), .RECORD_DEPTH(256), .STATUS_BITS(64),
                       .CHUNK_BITS(8), .STATUS_SNAPSHOT(0)) u_a (
    .scan_clk(scan_clk), .scan_reset_(scan_reset_),
    .status_shift_update(st_upd), .status_shift_ena(st_ena), .status_vec(status_vec),
    .status_shift_data(ss_a),
    .data_shift_update(upd_a), .data_shift_ena(ena_a), .data_shift_data(ds_a),
    .read_req_first(rf_a), .read_req_next(rn_a), .read_valid(rv_a), .read_data(rd_a),
    .data_underrun(ur_a), .data_done(dn_a), .word_cnt(wc_a));

  icetap_scan_stream #(.NR_SIGNALS(16), .RECORD_DEPTH(4), .STATUS_BITS(64),
                       .CHUNK_BITS(8), .STATUS_SNAPSHOT(1)) u_b (
    .scan_clk(scan_clk), .scan_reset_(scan_reset_),
    .status_shift_update(st_upd), .status_shift_ena(st_ena), .status_vec(status_vec),
    .status_shift_data(ss_b),
    .data_shift_update(upd_b), .data_shift_ena(ena_b), .data_shift_data(ds_b),
    .read_req_first(rf_b), .read_req_next(rn_b), .read_valid(rv_b), .read_data(rd_b),
    .data_underrun(ur_b), .data_done(dn_b), .word_cnt(wc_b));

  int n_tests = 0;
  int n_fail  = 0;

  bit q_a[$];
  bit q_b[$];

  // Memory models: one outstanding request, fixed latency, word table.
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];
  int lat_a = 2, lat_b = 2;
  int cnt_a = 0, cnt_b = 0;
  int idx_a = 0, idx_b = 0;

  initial begin : mem_a_proc
    rv_a = 1'b0; rd_a = '0;
    forever begin
      @(posedge scan_clk); #1;
      rv_a = 1'b0;
      if (rf_a || rn_a) begin
        if (rf_a) idx_a = 0;
        cnt_a = lat_a;
      end else if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          rv_a = 1'b1; rd_a = mem_a[idx_a]; idx_a = (idx_a + 1) % 4;
        end
      end
    end
  end

  initial begin : mem_b_proc
    rv_b = 1'b0; rd_b = '0;
    forever begin
      @(posedge scan_clk); #1;
      rv_b = 1'b0;
      if (rf_b || rn_b) begin
        if (rf_b) idx_b = 0;
        cnt_b = lat_b;
      end else if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          rv_b = 1'b1; rd_b = mem_b[idx_b]; idx_b = (idx_b + 1) % 4;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge scan_clk); #1;
  endtask

  initial begin : main
    logic [63:0] v0, v1;
    logic [15:0] w;
    int k, nreq;

    v0 = 64'h0123456789ABCDEF;
    v1 = 64'hFEDCBA9876543210;
    status_vec = '0; st_upd = 0; st_ena = 0;
    upd_a = 0; ena_a = 0; upd_b = 0; ena_b = 0;

    // ---------------- reset state
    repeat (3) tick();
    check("rst_ss_a", ss_a, 0);
    check("rst_ds_a", ds_a, 0);
    check("rst_rf_a", rf_a, 0);
    check("rst_rn_a", rn_a, 0);
    check("rst_ur_a", ur_a, 0);
    check("rst_dn_a", dn_a, 0);
    check("rst_wc_a", wc_a, 0);
    scan_reset_ = 1'b1;
    tick();
    check("release_rf_a", rf_a, 0);
    check("release_rf_b", rf_b, 0);

    // ---------------- status: full vector then 8 zeros
    status_vec = v0;
    st_upd = 1; tick(); st_upd = 0;
    for (int i = 0; i < 72; i++) begin
      q_a.push_back((i < 64) ? v0[i] : 1'b0);
      q_b.push_back((i < 64) ? v0[i] : 1'b0);
    end
    for (int i = 0; i < 72; i++) begin
      check("status_a", ss_a, q_a.pop_front());
      check("status_b", ss_b, q_b.pop_front());
      st_ena = 1; tick();
    end
    st_ena = 0;

    // ---------------- status: vector changes after update; update with ena
    status_vec = v0;
    st_upd = 1; st_ena = 1; tick();
    st_upd = 0; st_ena = 0; status_vec = v1;
    for (int i = 0; i < 72; i++) begin
      q_a.push_back((i < 8) ? v0[i] : (i < 64) ? v1[i] : 1'b0);
      q_b.push_back((i < 64) ? v0[i] : 1'b0);
    end
    for (int i = 0; i < 72; i++) begin
      check("status_live_a", ss_a, q_a.pop_front());
      check("status_snap_b", ss_b, q_b.pop_front());
      st_ena = 1; tick();
      st_ena = 0; tick();
    end

    // ---------------- data: two words back to back, latency 2
    mem_a[0] = 16'hA5A5; mem_a[1] = 16'h3C3C; mem_a[2] = 16'h1234; mem_a[3] = 16'h5678;
    lat_a = 2;
    for (int j = 0; j < 2; j++) begin
      w = mem_a[j];
      for (int i = 0; i < 16; i++) q_a.push_back(w[i]);
    end
    upd_a = 1; ena_a = 1; tick();
    upd_a = 0;
    check("d1_rf_first", rf_a, 1);
    check("d1_rn_early", rn_a, 0);
    check("d1_ds_cleared", ds_a, 0);
    tick();
    check("d1_rf_one_cycle", rf_a, 0);
    k = 0;
    while (!rn_a && k < 60) begin tick(); k++; end
    check("d1_rn_timeout", rn_a, 1);
    nreq = 0;
    for (int i = 0; i < 32; i++) begin
      check("d1_data", ds_a, q_a.pop_front());
      if (rn_a) nreq++;
      tick();
    end
    check("d1_rn_count", nreq, 2);
    check("d1_underrun", ur_a, 0);
    check("d1_word_cnt", wc_a, 2);
    ena_a = 0;

    // ---------------- data: late memory -> underrun, sticky until update
    mem_a[0] = 16'h1234; mem_a[1] = 16'h5678; mem_a[2] = 16'h9ABC; mem_a[3] = 16'hDEF0;
    lat_a = 20;
    w = mem_a[0];
    for (int i = 0; i < 16; i++) q_a.push_back(w[i]);
    upd_a = 1; ena_a = 1; tick();
    upd_a = 0;
    check("d2_rf_first", rf_a, 1);
    check("d2_ur_cleared", ur_a, 0);
    check("d2_wc_cleared", wc_a, 0);
    k = 0;
    while (!rn_a && k < 100) begin tick(); k++; end
    check("d2_rn_timeout", rn_a, 1);
    for (int i = 0; i < 16; i++) begin
      check("d2_data", ds_a, q_a.pop_front());
      tick();
    end
    check("d2_ur_before", ur_a, 0);
    check("d2_zero0", ds_a, 0);
    tick();
    check("d2_zero1", ds_a, 0);
    check("d2_underrun_set", ur_a, 1);
    repeat (30) tick();
    check("d2_underrun_sticky", ur_a, 1);
    upd_a = 1; tick();
    upd_a = 0; ena_a = 0;
    check("d2_upd_ur", ur_a, 0);
    check("d2_upd_wc", wc_a, 0);
    check("d2_upd_ds", ds_a, 0);
    check("d2_upd_rf", rf_a, 1);

    // ---------------- data: depth 4 -> done, saturation, no extra requests
    mem_b[0] = 16'hC001; mem_b[1] = 16'h8E21; mem_b[2] = 16'h7F00; mem_b[3] = 16'h0FF3;
    lat_b = 2;
    for (int j = 0; j < 4; j++) begin
      w = mem_b[j];
      for (int i = 0; i < 16; i++) q_b.push_back(w[i]);
    end
    nreq = 0;
    upd_b = 1; ena_b = 1; tick();
    upd_b = 0;
    check("d3_rf_first", rf_b, 1);
    if (rf_b) nreq++;
    tick();
    k = 0;
    while (!rn_b && k < 60) begin tick(); k++; end
    check("d3_rn_timeout", rn_b, 1);
    for (int i = 0; i < 64; i++) begin
      check("d3_data", ds_b, q_b.pop_front());
      if (rn_b || rf_b) nreq++;
      tick();
    end
    check("d3_word_cnt", wc_b, 4);
    check("d3_done", dn_b, 1);
    for (int i = 0; i < 10; i++) begin
      check("d3_after_done", ds_b, 0);
      if (rn_b || rf_b) nreq++;
      tick();
    end
    check("d3_req_count", nreq, 4);
    check("d3_no_underrun", ur_b, 0);
    check("d3_wc_saturated", wc_b, 4);
    check("d3_done_held", dn_b, 1);
    ena_b = 0;

    // ---------------- reset mid-word / mid-scan
    status_vec = '1;
    st_upd = 1; tick(); st_upd = 0;
    mem_a[0] = 16'hFFFF; mem_a[1] = 16'hFFFF; mem_a[2] = 16'hFFFF; mem_a[3] = 16'hFFFF;
    lat_a = 2;
    upd_a = 1; ena_a = 1; tick();
    upd_a = 0;
    k = 0;
    while (!rn_a && k < 60) begin tick(); k++; end
    check("r_rn_timeout", rn_a, 1);
    repeat (20) tick();
    check("r_pre_ds_a", ds_a, 1);
    check("r_pre_wc_a", wc_a, 1);
    check("r_pre_ss_a", ss_a, 1);
    check("r_pre_dn_b", dn_b, 1);
    #2 scan_reset_ = 1'b0;
    #1;
    check("r_ss_a", ss_a, 0);
    check("r_ss_b", ss_b, 0);
    check("r_ds_a", ds_a, 0);
    check("r_rf_a", rf_a, 0);
    check("r_rn_a", rn_a, 0);
    check("r_wc_a", wc_a, 0);
    check("r_wc_b", wc_b, 0);
    check("r_dn_b", dn_b, 0);
    ena_a = 0;
    tick(); tick();
    #2 scan_reset_ = 1'b1;
    tick(); tick();
    check("r_release_rf", rf_a, 0);
    check("r_release_rn", rn_a, 0);
    check("r_release_ds", ds_a, 0);

    // update coincident with ena: update wins, first request one cycle later
    upd_a = 1; ena_a = 1; tick();
    upd_a = 0; ena_a = 0;
    check("r_upd_rf", rf_a, 1);
    check("r_upd_ur", ur_a, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
